// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fetch_pkg;

    // Request presented / one request outstanding / outstanding response to discard
    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    // One buffered fetch result: the address it was fetched from and the word returned
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Force a target onto a word boundary
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry buffer of fetched {pc, instr} pairs between imem and decode.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push is dropped when full unless a pop happens in the same cycle; flush wins over everything.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output fetch_entry_t head_data,
    output logic         full,
    output logic         empty
);

    localparam logic [1:0] DEPTH_L = 2'(DEPTH);

    fetch_entry_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         do_push;
    logic         do_pop;

    assign empty     = (cnt == 2'd0);
    assign full      = (cnt == DEPTH_L);
    assign do_pop    = pop & ~empty;
    // Push into a full buffer is only legal when the head leaves in the same cycle
    assign do_push   = push & (~full | do_pop);
    assign head_data = mem[rd_ptr];

    // Pointer and occupancy tracking; flush empties the buffer without touching storage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Data storage; outputs are masked by the parent while empty, so no reset needed
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word fetches to imem, buffers results, hands {pc, instr} to decode.
// Latency: request registered one cycle after a decision; result at out_* the cycle after imem responds.
// Backpressure: out_ready low fills the 2-entry buffer, then imem_req_valid is held low; redirect flushes.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam logic [1:0] DEPTH_L = 2'(FIFO_DEPTH);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic [31:0]  pc;
    logic [31:0]  pc_nxt;
    logic [31:0]  acc_addr;
    logic         req_valid_q;
    logic         req_valid_nxt;

    logic         accept;
    logic         push;
    logic         pop;
    logic         outst;
    logic         outst_nxt;
    logic [1:0]   fifo_count;
    logic [1:0]   count_nxt;
    logic         fifo_full;
    logic         fifo_empty;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    assign accept     = (state == ST_REQ) & req_valid_q & imem_req_ready;
    // A response arriving together with a redirect is stale and never enters the buffer
    assign push       = (state == ST_WAIT) & imem_rsp_valid & ~redirect_valid;
    // A pop in a redirect cycle still completes for decode; the flush then clears the rest
    assign pop        = ~fifo_empty & out_ready;
    assign outst      = (state != ST_REQ);
    // Whether a request is still in flight after this cycle, regardless of redirect
    assign outst_nxt  = (outst & ~imem_rsp_valid) | accept;
    assign fifo_count = {fifo_full, ~fifo_full & ~fifo_empty};
    assign push_entry = '{pc: acc_addr, instr: imem_rsp_data};

    // Next occupancy, next state, next pc and next request-valid, all feeding registers only
    always_comb begin
        count_nxt     = fifo_count;
        state_nxt     = state;
        pc_nxt        = pc;
        req_valid_nxt = 1'b0;

        if (redirect_valid) begin
            count_nxt = 2'd0;
            pc_nxt    = align_pc(redirect_pc);
            state_nxt = outst_nxt ? ST_DRAIN : ST_REQ;
        end else begin
            count_nxt = fifo_count + {1'b0, push} - {1'b0, pop};
            if (accept) pc_nxt = pc + 32'd4;
            case (state)
                ST_REQ:   if (accept)         state_nxt = ST_WAIT;
                ST_WAIT:  if (imem_rsp_valid) state_nxt = ST_REQ;
                ST_DRAIN: if (imem_rsp_valid) state_nxt = ST_REQ;
                default:                      state_nxt = ST_REQ;
            endcase
        end

        // Only request when the result is guaranteed a buffer slot
        req_valid_nxt = (state_nxt == ST_REQ) && (count_nxt < DEPTH_L);
    end

    // Fetch control FSM with registered request outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_REQ;
            pc          <= RESET_PC;
            acc_addr    <= 32'h0;
            req_valid_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            req_valid_q <= req_valid_nxt;
            if (accept) acc_addr <= pc;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (push_entry),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc;
    assign out_valid      = ~fifo_empty;
    assign out_pc         = fifo_empty ? 32'h0 : head_entry.pc;
    assign out_instr      = fifo_empty ? 32'h0 : head_entry.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table plus hand sequences for stall, wrap, ready-low and reset.
// Latency: the bench memory answers one cycle after each accepted request.
// Backpressure: out_ready and imem_req_ready are driven per cycle from the vectors.
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        mem_rdy;
        logic        o_rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_ov;
        logic [31:0] exp_opc;
    } vec_t;

    vec_t vecs [15];

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word the bench memory returns for a given address
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    function automatic vec_t mk(input logic mr, input logic orr, input logic rd, input logic [31:0] rp,
                                input logic rv, input logic [31:0] ad, input logic ov, input logic [31:0] op);
        vec_t v;
        v.mem_rdy = mr; v.o_rdy = orr; v.redir = rd; v.rpc = rp;
        v.exp_rv = rv; v.exp_addr = ad; v.exp_ov = ov; v.exp_opc = op;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic rv, input logic [31:0] addr,
                             input logic ov, input logic [31:0] opc);
        check1 ({tag, ".req_valid"}, imem_req_valid, rv);
        check32({tag, ".req_addr"},  imem_req_addr,  addr);
        check1 ({tag, ".out_valid"}, out_valid,      ov);
        check32({tag, ".out_pc"},    out_pc,         ov ? opc : 32'h0);
        check32({tag, ".out_instr"}, out_instr,      ov ? instr_of(opc) : 32'h0);
    endtask

    // One clock: drive inputs, let the edge happen, then update the 1-cycle-latency memory
    task automatic cycle(input logic mr, input logic orr, input logic rd, input logic [31:0] rp);
        logic        acc;
        logic [31:0] a;
        imem_req_ready = mr;
        out_ready      = orr;
        redirect_valid = rd;
        redirect_pc    = rp;
        acc = imem_req_valid & imem_req_ready;
        a   = imem_req_addr;
        @(posedge clk);
        #1;
        imem_rsp_valid = acc & reset_n;
        imem_rsp_data  = acc ? instr_of(a) : 32'h0;
        redirect_valid = 1'b0;
    endtask

    initial begin
        // Steady stream, redirect in WAIT with simultaneous stale response,
        // then redirect coinciding with an acceptance and a pop (goes through DRAIN)
        vecs[0]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0000, 1'b0, 32'h0);
        vecs[1]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0000_0004, 1'b0, 32'h0);
        vecs[2]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000);
        vecs[3]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0000_0008, 1'b0, 32'h0);
        vecs[4]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004);
        vecs[5]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0000_000C, 1'b0, 32'h0);
        vecs[6]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008);
        vecs[7]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0000_0010, 1'b0, 32'h0);
        vecs[8]  = mk(1'b1, 1'b1, 1'b1, 32'h102, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
        vecs[9]  = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0000_0104, 1'b0, 32'h0);
        vecs[10] = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100);
        vecs[11] = mk(1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0000_0200, 1'b0, 32'h0);
        vecs[12] = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0200, 1'b0, 32'h0);
        vecs[13] = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0000_0204, 1'b0, 32'h0);
        vecs[14] = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0000_0204, 1'b1, 32'h0000_0200);

        reset_n        = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 32'h0, 1'b0, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].mem_rdy, vecs[i].o_rdy, vecs[i].redir, vecs[i].rpc);
            check_out($sformatf("vec%0d", i), vecs[i].exp_rv, vecs[i].exp_addr,
                      vecs[i].exp_ov, vecs[i].exp_opc);
        end

        // Decode stalled for 10 cycles: buffer fills to 2, requests stop
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_out("stall0", 1'b0, 32'h0000_0208, 1'b1, 32'h0000_0200);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_out("stall1", 1'b0, 32'h0000_0208, 1'b1, 32'h0000_0200);
        for (int k = 2; k < 10; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
            check_out($sformatf("stall%0d", k), 1'b0, 32'h0000_0208, 1'b1, 32'h0000_0200);
        end
        // Release: two entries drain in order, then fetch resumes
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check_out("drain0", 1'b1, 32'h0000_0208, 1'b1, 32'h0000_0204);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check_out("drain1", 1'b0, 32'h0000_020C, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check_out("drain2", 1'b1, 32'h0000_020C, 1'b1, 32'h0000_0208);

        // Address wrap at the top of the address space
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        check_out("wrap0", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_out("wrap1", 1'b0, 32'h0000_0000, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_out("wrap2", 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC);

        // imem not ready for 3 cycles; redirect (unaligned target) in the second
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_out("nrdy0", 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0301);
        check_out("nrdy1", 1'b1, 32'h0000_0300, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_out("nrdy2", 1'b1, 32'h0000_0300, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_out("nrdy3", 1'b0, 32'h0000_0304, 1'b0, 32'h0);

        // Reset while a response is outstanding
        reset_n        = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        check_out("rstmid0", 1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_out("rstmid1", 1'b0, 32'h0, 1'b0, 32'h0);
        reset_n = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check_out("restart0", 1'b1, 32'h0000_0000, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check_out("restart1", 1'b0, 32'h0000_0004, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        check_out("restart2", 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
